// File: rtl/td4_pkg.sv
// Shared TD4 definitions: opcode encodings, active-low register load enables
// and the adder source selection used by the decoder.
package td4_pkg;

    typedef enum logic [3:0] {
        OP_ADD_A    = 4'b0000,
        OP_MOV_A_B  = 4'b0001,
        OP_IN_A     = 4'b0010,
        OP_MOV_A_IM = 4'b0011,
        OP_MOV_B_A  = 4'b0100,
        OP_ADD_B    = 4'b0101,
        OP_IN_B     = 4'b0110,
        OP_MOV_B_IM = 4'b0111,
        OP_OUT_B    = 4'b1001,
        OP_OUT_IM   = 4'b1011,
        OP_JNC      = 4'b1110,
        OP_JMP      = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_IN   = 2'd3
    } src_sel_e;

    // Active-low one-hot: bit0 A, bit1 B, bit2 OUT, bit3 PC
    localparam logic [3:0] LOAD_A    = 4'b1110;
    localparam logic [3:0] LOAD_B    = 4'b1101;
    localparam logic [3:0] LOAD_OUT  = 4'b1011;
    localparam logic [3:0] LOAD_PC   = 4'b0111;
    localparam logic [3:0] LOAD_NONE = 4'b1111;

endpackage

// File: rtl/in_sync.sv
// Multi-flop synchronizer bringing the asynchronous input switches into the
// CLK domain; output is the last stage of the chain.
module in_sync #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sync_q [DEPTH];

    // Shift chain, cleared asynchronously on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_o = sync_q[DEPTH-1];

endmodule

// File: rtl/decode_execute.sv
// TD4 decode/execute stage: decodes INSTR, adds the selected source to the
// immediate, drives register load enables and keeps carry/halt/retire state.
module decode_execute
    import td4_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] INSTR,
    input  logic [3:0] ADDRESS,
    input  logic [3:0] REG_A,
    input  logic [3:0] REG_B,
    input  logic [3:0] IN_PORT,
    output logic [3:0] LOAD,
    output logic [3:0] IN_DATA,
    output logic       CARRY,
    output logic       HALTED,
    output logic [7:0] RETIRED
);

    opcode_e    op_s;
    logic [3:0] im_s;
    logic [3:0] in_sync_s;
    src_sel_e   src_sel_s;
    logic [3:0] src_s;
    logic [3:0] load_s;
    logic       defined_s;
    logic [4:0] sum_s;
    logic       pc_load_s;

    logic       carry_q,   carry_d;
    logic       halted_q,  halted_d;
    logic [7:0] retired_q, retired_d;

    assign op_s = opcode_e'(INSTR[7:4]);
    assign im_s = INSTR[3:0];

    in_sync #(
        .DEPTH (SYNC_STAGES),
        .WIDTH (4)
    ) u_in_sync (
        .clk_i  (CLK),
        .rst_i  (RST),
        .data_i (IN_PORT),
        .data_o (in_sync_s)
    );

    // Opcode decode: adder source and destination enable
    always_comb begin
        src_sel_s = SRC_ZERO;
        load_s    = LOAD_NONE;
        defined_s = 1'b1;
        case (op_s)
            OP_ADD_A:    begin src_sel_s = SRC_A;  load_s = LOAD_A;   end
            OP_ADD_B:    begin src_sel_s = SRC_B;  load_s = LOAD_B;   end
            OP_MOV_A_IM: begin                     load_s = LOAD_A;   end
            OP_MOV_B_IM: begin                     load_s = LOAD_B;   end
            OP_MOV_A_B:  begin src_sel_s = SRC_B;  load_s = LOAD_A;   end
            OP_MOV_B_A:  begin src_sel_s = SRC_A;  load_s = LOAD_B;   end
            OP_IN_A:     begin src_sel_s = SRC_IN; load_s = LOAD_A;   end
            OP_IN_B:     begin src_sel_s = SRC_IN; load_s = LOAD_B;   end
            OP_OUT_B:    begin src_sel_s = SRC_B;  load_s = LOAD_OUT; end
            OP_OUT_IM:   begin                     load_s = LOAD_OUT; end
            OP_JMP:      begin                     load_s = LOAD_PC;  end
            OP_JNC:      begin load_s = carry_q ? LOAD_NONE : LOAD_PC; end
            default:     begin defined_s = 1'b0; end
        endcase
    end

    // Adder source multiplexer
    always_comb begin
        src_s = 4'h0;
        case (src_sel_s)
            SRC_A:   src_s = REG_A;
            SRC_B:   src_s = REG_B;
            SRC_IN:  src_s = in_sync_s;
            default: src_s = 4'h0;
        endcase
    end

    assign sum_s     = {1'b0, src_s} + {1'b0, im_s};
    assign pc_load_s = (load_s == LOAD_PC);

    // Next-state for flags; undefined opcodes leave carry untouched
    always_comb begin
        carry_d   = defined_s ? sum_s[4] : carry_q;
        halted_d  = halted_q | (pc_load_s && (im_s == ADDRESS));
        retired_d = (retired_q == 8'hFF) ? retired_q : retired_q + 8'd1;
    end

    // Flag and retire-count registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            carry_q   <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= 8'd0;
        end else begin
            carry_q   <= carry_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    // Reset masks the combinational write path so no register loads during reset
    assign LOAD    = RST ? LOAD_NONE : load_s;
    assign IN_DATA = RST ? 4'h0 : sum_s[3:0];
    assign CARRY   = carry_q;
    assign HALTED  = halted_q;
    assign RETIRED = retired_q;

endmodule

// File: tb/tb_decode_execute.sv
// Self-checking bench for decode_execute: reference model from the instruction
// table plus directed vectors with hand-computed expectations.
module tb_decode_execute;

    localparam int SS = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] INSTR = 8'h00;
    logic [3:0] ADDRESS = 4'h0;
    logic [3:0] REG_A = 4'h0;
    logic [3:0] REG_B = 4'h0;
    logic [3:0] IN_PORT = 4'h0;
    logic [3:0] LOAD;
    logic [3:0] IN_DATA;
    logic       CARRY;
    logic       HALTED;
    logic [7:0] RETIRED;

    int errors = 0;
    int checks = 0;

    decode_execute #(.SYNC_STAGES(SS)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .INSTR   (INSTR),
        .ADDRESS (ADDRESS),
        .REG_A   (REG_A),
        .REG_B   (REG_B),
        .IN_PORT (IN_PORT),
        .LOAD    (LOAD),
        .IN_DATA (IN_DATA),
        .CARRY   (CARRY),
        .HALTED  (HALTED),
        .RETIRED (RETIRED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_carry   = 1'b0;
    logic       m_halted  = 1'b0;
    int         m_retired = 0;
    logic [3:0] m_hist [4] = '{4'h0, 4'h0, 4'h0, 4'h0};  // IN_PORT at past edges, [0] newest

    // Instruction semantics straight from the instruction table
    function automatic void model_exec(input logic [7:0] instr, input logic [3:0] a, b, insync,
                                       input logic carry, output logic [3:0] load,
                                       output logic [3:0] data, output logic cout,
                                       output logic defined);
        int src;
        int im;
        int sum;
        im = int'(instr[3:0]);
        src = 0;
        load = 4'b1111;
        defined = 1'b1;
        case (instr[7:4])
            4'b0000: begin src = int'(a);      load = 4'b1110; end
            4'b0101: begin src = int'(b);      load = 4'b1101; end
            4'b0011: begin                     load = 4'b1110; end
            4'b0111: begin                     load = 4'b1101; end
            4'b0001: begin src = int'(b);      load = 4'b1110; end
            4'b0100: begin src = int'(a);      load = 4'b1101; end
            4'b0010: begin src = int'(insync); load = 4'b1110; end
            4'b0110: begin src = int'(insync); load = 4'b1101; end
            4'b1001: begin src = int'(b);      load = 4'b1011; end
            4'b1011: begin                     load = 4'b1011; end
            4'b1111: begin                     load = 4'b0111; end
            4'b1110: begin load = carry ? 4'b1111 : 4'b0111; end
            default: defined = 1'b0;
        endcase
        sum  = src + im;
        data = 4'(sum % 16);
        cout = (sum >= 16);
    endfunction

    // Model state advance on each edge
    always @(posedge CLK or posedge RST) begin
        logic [3:0] ld;
        logic [3:0] dt;
        logic       co;
        logic       df;
        if (RST) begin
            m_carry = 1'b0; m_halted = 1'b0; m_retired = 0;
            for (int i = 0; i < 4; i++) m_hist[i] = 4'h0;
        end else begin
            model_exec(INSTR, REG_A, REG_B, m_hist[SS-1], m_carry, ld, dt, co, df);
            if (df) m_carry = co;
            if (ld == 4'b0111 && INSTR[3:0] == ADDRESS) m_halted = 1'b1;
            m_retired = (m_retired < 255) ? m_retired + 1 : 255;
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = IN_PORT;
        end
    end

    // Compare process: every falling edge
    always @(negedge CLK) begin
        logic [3:0] ld;
        logic [3:0] dt;
        logic       co;
        logic       df;
        model_exec(INSTR, REG_A, REG_B, m_hist[SS-1], m_carry, ld, dt, co, df);
        if (RST) begin
            ld = 4'b1111;
            dt = 4'h0;
        end
        chk("cmp_load",    {4'h0, LOAD},    {4'h0, ld});
        chk("cmp_in_data", {4'h0, IN_DATA}, {4'h0, dt});
        chk("cmp_carry",   {7'h0, CARRY},   {7'h0, m_carry});
        chk("cmp_halted",  {7'h0, HALTED},  {7'h0, m_halted});
        chk("cmp_retired", RETIRED, 8'(m_retired));
        chk("cmp_load_onehot", 8'($countones(~LOAD) <= 1), 8'h01);
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [7:0] i, input logic [3:0] addr, a, b, p);
        INSTR = i; ADDRESS = addr; REG_A = a; REG_B = b; IN_PORT = p;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        tick();
        tick();
        // Reset forcing, with an ADD presented
        drive(8'h05, 4'h0, 4'hC, 4'h0, 4'h0);
        chk("rst_load",    {4'h0, LOAD}, 8'h0F);
        chk("rst_in_data", {4'h0, IN_DATA}, 8'h00);
        chk("rst_carry",   {7'h0, CARRY}, 8'h00);
        chk("rst_halted",  {7'h0, HALTED}, 8'h00);
        chk("rst_retired", RETIRED, 8'h00);
        RST = 1'b0;
        #1;
        // ADD A,5 with A=C
        chk("add_a_data", {4'h0, IN_DATA}, 8'h01);
        chk("add_a_load", {4'h0, LOAD}, 8'h0E);
        tick();
        chk("add_a_carry", {7'h0, CARRY}, 8'h01);
        chk("first_retired", RETIRED, 8'h01);

        // JNC with carry set, then with carry clear
        drive(8'hE3, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("jnc_taken_not_load", {4'h0, LOAD}, 8'h0F);
        tick();
        chk("jnc_clears_carry", {7'h0, CARRY}, 8'h00);
        drive(8'hE3, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("jnc_taken_load", {4'h0, LOAD}, 8'h07);
        chk("jnc_taken_data", {4'h0, IN_DATA}, 8'h03);
        tick();

        // Wrap-around F+1
        drive(8'h01, 4'h0, 4'hF, 4'h0, 4'h0);
        chk("wrap_data", {4'h0, IN_DATA}, 8'h00);
        tick();
        chk("wrap_carry", {7'h0, CARRY}, 8'h01);

        // Undefined opcode keeps carry
        drive(8'h8F, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("nop_load", {4'h0, LOAD}, 8'h0F);
        chk("nop_data", {4'h0, IN_DATA}, 8'h0F);
        tick();
        chk("nop_carry_kept", {7'h0, CARRY}, 8'h01);

        // Sweep every opcode (address never equals IM)
        for (int op = 0; op < 16; op++) begin
            drive({4'(op), 4'(op + 3)}, 4'(op + 4), 4'h9, 4'h6, 4'h3);
            tick();
        end
        chk("sweep_not_halted", {7'h0, HALTED}, 8'h00);

        // Self-jump halts, sticky
        drive(8'hF7, 4'h7, 4'h0, 4'h0, 4'h3);
        chk("halt_load", {4'h0, LOAD}, 8'h07);
        tick();
        chk("halt_set", {7'h0, HALTED}, 8'h01);
        drive(8'h02, 4'h7, 4'h1, 4'h2, 4'h3);
        tick();
        drive(8'h31, 4'h7, 4'h1, 4'h2, 4'h3);
        tick();
        chk("halt_sticky", {7'h0, HALTED}, 8'h01);

        // Synchronizer latency
        drive(8'h80, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) tick();
        drive(8'h20, 4'h0, 4'h0, 4'h0, 4'hA);
        chk("in_sync_0", {4'h0, IN_DATA}, 8'h00);
        for (int k = 1; k <= SS; k++) begin
            tick();
            #1;
            chk("in_sync_lat", {4'h0, IN_DATA}, (k == SS) ? 8'h0A : 8'h00);
        end

        // Asynchronous reset between edges
        drive(8'h0F, 4'h0, 4'hF, 4'h0, 4'h0);
        tick();
        chk("pre_rst_carry", {7'h0, CARRY}, 8'h01);
        chk("pre_rst_halted", {7'h0, HALTED}, 8'h01);
        RST = 1'b1;
        #1;
        chk("async_rst_carry",  {7'h0, CARRY}, 8'h00);
        chk("async_rst_halted", {7'h0, HALTED}, 8'h00);
        chk("async_rst_load",   {4'h0, LOAD}, 8'h0F);
        chk("async_rst_retired", RETIRED, 8'h00);
        RST = 1'b0;

        // Retire counter saturation
        drive(8'h80, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 300; k++) tick();
        chk("retired_sat", RETIRED, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
